// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store size codes
// and the responder FSM state encoding.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/half out of a little-endian word and sign- or
// zero-extends it according to the RV32I load size code.
module load_extender
  import riscv_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'd0, w_half};
      F3_LW:   o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store at a time, serviced from an
// internal word array after WAIT_CYCLES wait states, answered over valid/ready.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [2:0]       req_funct3,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [1:0]       dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the payload is sampled on that edge and valid may not depend on ready.
  mem_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_oor, w_misalign, w_bad_f3, w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word, w_ext, w_wlanes;
  logic [3:0]    w_be;

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign dbg_state = r_state;

  // Gating with reset keeps a request presented during reset from touching the array.
  assign w_accept = req_valid && req_ready && reset;
  assign w_idx    = req_addr[AW+1:2];
  assign w_oor    = (32'(req_addr) >= ADDR_LIMIT);
  assign w_err    = w_oor || w_misalign || w_bad_f3;

  always_comb begin
    w_misalign = 1'b0;
    w_bad_f3   = 1'b0;
    case (req_funct3)
      F3_LB:          w_bad_f3 = 1'b0;
      F3_LBU, F3_LHU: w_bad_f3 = req_write;
      F3_LH:          w_bad_f3 = 1'b0;
      F3_LW:          w_bad_f3 = 1'b0;
      default:        w_bad_f3 = 1'b1;
    endcase
    if (req_funct3 == F3_LH || req_funct3 == F3_LHU) w_misalign = req_addr[0];
    if (req_funct3 == F3_LW) w_misalign = (req_addr[1:0] != 2'b00);
  end

  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = req_wdata[31:0];
    case (req_funct3)
      F3_LB: begin
        w_be     = 4'b0001 << req_addr[1:0];
        w_wlanes = {4{req_wdata[7:0]}};
      end
      F3_LH: begin
        w_be     = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{req_wdata[15:0]}};
      end
      F3_LW:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_word = r_mem[w_idx];

  load_extender u_load_extender (
    .i_word    (w_word),
    .i_addr_lo (req_addr[1:0]),
    .i_funct3  (req_funct3),
    .o_data    (w_ext)
  );

  // The array has no reset so a store committed before a reset survives it.
  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_RESP;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_err   <= w_err;
        r_rdata <= (req_write || w_err) ? 32'd0 : w_ext;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: runs the same vector suite against a
// WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        sel;
  int          cur_wait;
  int          n_vec = 0;
  int          n_bad = 0;

  logic        req_ready_a, rsp_valid_a, rsp_err_a, req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;
  logic [1:0]  dbg_a, dbg_b;
  logic        req_ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_rdata_m;

  always #5 clk = ~clk;

  data_mem_responder #(.WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid && !sel), .req_ready(req_ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready || sel),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .dbg_state(dbg_a)
  );

  data_mem_responder #(.WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid && sel), .req_ready(req_ready_b),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready || !sel),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .dbg_state(dbg_b)
  );

  assign req_ready_m = sel ? req_ready_b : req_ready_a;
  assign rsp_valid_m = sel ? rsp_valid_b : rsp_valid_a;
  assign rsp_err_m   = sel ? rsp_err_b   : rsp_err_a;
  assign rsp_rdata_m = sel ? rsp_rdata_b : rsp_rdata_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s (wait=%0d): got 0x%08h expected 0x%08h", tag, cur_wait, obs, exp);
    end
  endtask

  task automatic wait_ready_then_accept();
    int t;
    t = 0;
    while (!req_ready_m && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int lat;
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b1; req_write = wr;
    req_funct3 = f3; req_addr = addr; req_wdata = wd;
    wait_ready_then_accept();
    // Scramble request fields after acceptance; the DUT must have captured them.
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
    lat = 0;
    while (!rsp_valid_m && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, cur_wait);
    rd = rsp_rdata_m;
    er = rsp_err_m;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input string tag, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    do_req(wr, f3, addr, wd, rd, er);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
  endtask

  task automatic run_suite();
    logic [31:0] hold_d;
    logic        seen;
    int          t;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready_m}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid_m}, 32'd0);
    chk("rst_rdata", rsp_rdata_m, 32'd0);
    chk("rst_err", {31'd0, rsp_err_m}, 32'd0);

    expect_rsp("sw_10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    expect_rsp("lw_10", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    chk("valid_drop", {31'd0, rsp_valid_m}, 32'd0);
    chk("rdata_kept", rsp_rdata_m, 32'hDEADBEEF);

    expect_rsp("lb_13", 1'b0, F3_B, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    expect_rsp("lbu_13", 1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    expect_rsp("lh_10", 1'b0, F3_H, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    expect_rsp("lhu_12", 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);

    expect_rsp("sh_12", 1'b1, F3_H, 32'h12, 32'hAAAA1234, 32'd0, 1'b0);
    expect_rsp("sb_10", 1'b1, F3_B, 32'h10, 32'h77777755, 32'd0, 1'b0);
    expect_rsp("lw_merge", 1'b0, F3_W, 32'h10, 32'h0, 32'h1234BE55, 1'b0);
    expect_rsp("lb_11", 1'b0, F3_B, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);

    expect_rsp("lw_mis", 1'b0, F3_W, 32'h11, 32'h0, 32'd0, 1'b1);
    expect_rsp("sh_mis", 1'b1, F3_H, 32'h13, 32'hFFFFFFFF, 32'd0, 1'b1);
    expect_rsp("lw_oor", 1'b0, F3_W, 32'(4 * DEPTH), 32'h0, 32'd0, 1'b1);
    expect_rsp("sw_hi", 1'b1, F3_W, 32'h80000010, 32'h11111111, 32'd0, 1'b1);
    expect_rsp("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'd0, 1'b1);
    expect_rsp("sbu", 1'b1, F3_BU, 32'h10, 32'h99999999, 32'd0, 1'b1);
    expect_rsp("lw_after_err", 1'b0, F3_W, 32'h10, 32'h0, 32'h1234BE55, 1'b0);

    // Backpressure: response held, a competing request waits.
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
    wait_ready_then_accept();
    req_valid = 1'b0;
    t = 0;
    while (!rsp_valid_m && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    hold_d = rsp_rdata_m;
    chk("hold_first", hold_d, 32'h1234BE55);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h14; req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, rsp_valid_m}, 32'd1);
      chk("hold_rdata", rsp_rdata_m, 32'h1234BE55);
      chk("hold_err", {31'd0, rsp_err_m}, 32'd0);
      chk("hold_req_ready", {31'd0, req_ready_m}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_req_ready", {31'd0, req_ready_m}, 32'd1);
    chk("hs_valid_low", {31'd0, rsp_valid_m}, 32'd0);
    @(posedge clk);
    #1;
    chk("pending_accepted", {31'd0, req_ready_m}, 32'd0);
    req_valid = 1'b0;
    t = 0;
    while (!rsp_valid_m && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("pending_err", {31'd0, rsp_err_m}, 32'd0);
    @(posedge clk);
    #1;
    expect_rsp("lw_14", 1'b0, F3_W, 32'h14, 32'h0, 32'h0BADF00D, 1'b0);

    // Reset while a store is in flight: response dropped, store already committed.
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    wait_ready_then_accept();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    seen = rsp_valid_m;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid_m) seen = 1'b1;
    end
    chk("rst_no_rsp", {31'd0, seen}, 32'd0);
    chk("rst_ready_after", {31'd0, req_ready_m}, 32'd1);
    expect_rsp("lw_20", 1'b0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b1;
    req_addr = '0; req_wdata = '0; req_funct3 = F3_W;
    sel = 1'b0; cur_wait = 2;
    run_suite();
    sel = 1'b1; cur_wait = 0;
    run_suite();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
